uart_rx_packet: RTL and testbench

//  Receive side of the team's 14-byte UART link. Deserialises 8-bit frames from the serial line
//  (start, 8 data LSB-first, parity, stop) and assembles NUM_BYTES frames into one packet register.

---
 rtl/uart_rx_packet.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_packet.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_packet.sv
// UART packet receiver: 8-bit frames with parity, assembled into NUM_BYTES packets.
// Bytes gather in a staging register so packet_data only changes on packet_valid.
module uart_rx_packet #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_TYPE  = 0,
  parameter int NUM_BYTES    = 14,
  parameter int GAP_TIMEOUT  = 50000
) (
  input  logic                   clk_50M,
  input  logic                   rst_n,
  input  logic                   rx,
  output logic [8*NUM_BYTES-1:0] packet_data,
  output logic                   packet_valid,
  output logic                   byte_valid,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  localparam int IW = $clog2(NUM_BYTES);
  localparam int PW = 8 * NUM_BYTES;

  localparam logic [CW-1:0] HALF    = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL    = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST    = IW'(NUM_BYTES - 1);
  localparam logic [GW-1:0] GAP_END = GW'(GAP_TIMEOUT - 1);
  localparam logic          PT      = 1'(PARITY_TYPE);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state, state_nxt;

  logic          rx_m, rx_s;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic [IW-1:0] idx;
  logic [GW-1:0] gap_cnt;
  logic [PW-1:0] stage;
  logic [PW-1:0] stage_nxt;
  logic          wait_hi;

  logic cnt_clr;
  logic start_det;
  logic smp_data;
  logic smp_par;
  logic smp_stop;
  logic par_ok;
  logic gap_hit;

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    start_det = 1'b0;
    smp_data  = 1'b0;
    smp_par   = 1'b0;
    smp_stop  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_s && !wait_hi) begin
          state_nxt = START;
          start_det = 1'b1;
        end
      end
      START: begin
        if (clk_cnt == HALF) begin
          cnt_clr   = 1'b1;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt == FULL) begin
          cnt_clr  = 1'b1;
          smp_data = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (clk_cnt == FULL) begin
          cnt_clr   = 1'b1;
          smp_par   = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (clk_cnt == FULL) begin
          cnt_clr   = 1'b1;
          smp_stop  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stage_nxt = stage;
    stage_nxt[int'(idx)*8 +: 8] = shift;
  end

  assign par_ok  = (par_bit == (^shift ^ PT));
  assign gap_hit = (state == IDLE) && !start_det &&
                   (idx != '0) && (gap_cnt == GAP_END);
  assign busy    = (idx != '0) || (state != IDLE);

  always_ff @(posedge clk_50M) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      rx_m         <= 1'b1;
      rx_s         <= 1'b1;
      clk_cnt      <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      par_bit      <= 1'b0;
      idx          <= '0;
      gap_cnt      <= '0;
      stage        <= '0;
      wait_hi      <= 1'b0;
      packet_data  <= '0;
      packet_valid <= 1'b0;
      byte_valid   <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      rx_m         <= rx;
      rx_s         <= rx_m;
      packet_valid <= 1'b0;
      byte_valid   <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;

      clk_cnt <= cnt_clr ? '0 : clk_cnt + 1'b1;

      if (start_det) bit_cnt <= '0;
      if (smp_data) begin
        shift[bit_cnt] <= rx_s;
        bit_cnt        <= bit_cnt + 1'b1;
      end
      if (smp_par) par_bit <= rx_s;

      // a break keeps the line low; no new start until it idles high
      if (smp_stop && !rx_s)           wait_hi <= 1'b1;
      else if (state == IDLE && rx_s)  wait_hi <= 1'b0;

      if (start_det || idx == '0 || gap_hit) gap_cnt <= '0;
      else if (state == IDLE)                gap_cnt <= gap_cnt + 1'b1;

      if (smp_stop) begin
        if (!rx_s) begin
          frame_err <= 1'b1;
          idx       <= '0;
        end else if (!par_ok) begin
          parity_err <= 1'b1;
          idx        <= '0;
        end else begin
          byte_valid <= 1'b1;
          stage      <= stage_nxt;
          if (idx == LAST) begin
            packet_data  <= stage_nxt;
            packet_valid <= 1'b1;
            idx          <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
      end else if (gap_hit) begin
        frame_err <= 1'b1;
        idx       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_packet.sv
// Directed bench for uart_rx_packet: good packets, parity/stop/gap errors,
// glitch rejection, mid-frame reset and an odd-parity instance.
module tb_uart_rx_packet;

  localparam int CPB = 16;
  localparam int GAP = 2000;
  localparam int NB  = 14;
  localparam int PW  = 8 * NB;

  logic clk_50M = 1'b0;
  logic rst_n   = 1'b0;
  logic rx0     = 1'b1;
  logic rx1     = 1'b1;

  logic [PW-1:0] pd0, pd1;
  logic pv0, bv0, pe0, fe0, by0;
  logic pv1, bv1, pe1, fe1, by1;

  always #5 clk_50M = ~clk_50M;

  uart_rx_packet #(
    .CLKS_PER_BIT(CPB), .PARITY_TYPE(0),
    .NUM_BYTES(NB), .GAP_TIMEOUT(GAP)
  ) u_even (
    .clk_50M(clk_50M), .rst_n(rst_n), .rx(rx0),
    .packet_data(pd0), .packet_valid(pv0),
    .byte_valid(bv0), .parity_err(pe0),
    .frame_err(fe0), .busy(by0)
  );

  uart_rx_packet #(
    .CLKS_PER_BIT(CPB), .PARITY_TYPE(1),
    .NUM_BYTES(NB), .GAP_TIMEOUT(GAP)
  ) u_odd (
    .clk_50M(clk_50M), .rst_n(rst_n), .rx(rx1),
    .packet_data(pd1), .packet_valid(pv1),
    .byte_valid(bv1), .parity_err(pe1),
    .frame_err(fe1), .busy(by1)
  );

  int total = 0;
  int bad   = 0;

  int nbv = 0, npv = 0, npe = 0, nfe = 0, nsync = 0;
  int obv = 0, opv = 0, ope = 0;

  always @(posedge clk_50M) begin
    if (bv0) nbv <= nbv + 1;
    if (pv0) npv <= npv + 1;
    if (pe0) npe <= npe + 1;
    if (fe0) nfe <= nfe + 1;
    if (pv0 && !bv0) nsync <= nsync + 1;
    if (bv1) obv <= obv + 1;
    if (pv1) opv <= opv + 1;
    if (pe1) ope <= ope + 1;
  end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [7:0] base);
    logic [PW-1:0] r;
    r = '0;
    for (int k = 0; k < NB; k++) r[8*k +: 8] = base + 8'(k);
    return r;
  endfunction

  task automatic drive(input bit odd, input logic b);
    if (odd) rx1 = b;
    else     rx0 = b;
    repeat (CPB) @(negedge clk_50M);
  endtask

  task automatic send(input logic [7:0] d, input bit flip_par,
                      input bit stop_lo, input bit odd);
    logic [10:0] bits;
    logic p;
    p    = ^d ^ odd ^ flip_par;
    bits = {~stop_lo, p, d, 1'b0};
    for (int i = 0; i < 11; i++) drive(odd, bits[i]);
    if (odd) rx1 = 1'b1;
    else     rx0 = 1'b1;
    repeat (4) @(negedge clk_50M);
  endtask

  task automatic send_pkt(input logic [7:0] base, input bit odd);
    for (int k = 0; k < NB; k++) send(base + 8'(k), 1'b0, 1'b0, odd);
  endtask

  int sbv, spv, spe, sfe, sopv, sope, waited;

  initial begin
    repeat (4) @(negedge clk_50M);
    chk("rst_data", pd0, '0);
    chk("rst_flags", {pv0, bv0, pe0, fe0, by0}, 5'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk_50M);

    // good packet 0x00..0x0D
    sbv = nbv; spv = npv;
    send_pkt(8'h00, 1'b0);
    chk("t1_bytes", nbv - sbv, NB);
    chk("t1_pkts", npv - spv, 1);
    chk("t1_data", pd0, mk(8'h00));
    chk("t1_b13", pd0[111:104], 8'h0D);
    chk("t1_busy", by0, 1'b0);

    // bad parity on frame 5, then full resend
    spv = npv; spe = npe; sfe = nfe;
    for (int k = 0; k < 5; k++) send(8'(k), 1'b0, 1'b0, 1'b0);
    chk("t2_busy_mid", by0, 1'b1);
    send(8'h05, 1'b1, 1'b0, 1'b0);
    chk("t2_perr", npe - spe, 1);
    chk("t2_ferr", nfe - sfe, 0);
    chk("t2_nopkt", npv - spv, 0);
    chk("t2_busy", by0, 1'b0);
    send_pkt(8'h20, 1'b0);
    chk("t2_pkts", npv - spv, 1);
    chk("t2_data", pd0, mk(8'h20));

    // stop bit low
    sbv = nbv; spe = npe; sfe = nfe;
    send(8'hA5, 1'b0, 1'b1, 1'b0);
    chk("t3_ferr", nfe - sfe, 1);
    chk("t3_perr", npe - spe, 0);
    chk("t3_nobyte", nbv - sbv, 0);
    chk("t3_keep", pd0, mk(8'h20));
    chk("t3_busy", by0, 1'b0);

    // gap timeout after 3 frames
    spv = npv; sfe = nfe;
    for (int k = 0; k < 3; k++) send(8'h50 + 8'(k), 1'b0, 1'b0, 1'b0);
    chk("t4_busy", by0, 1'b1);
    waited = 0;
    while (nfe == sfe && waited < GAP + 500) begin
      @(negedge clk_50M);
      waited++;
    end
    chk("t4_ferr", nfe - sfe, 1);
    chk("t4_late", waited >= GAP - 100, 1'b1);
    chk("t4_idle", by0, 1'b0);
    send_pkt(8'h40, 1'b0);
    chk("t4_pkts", npv - spv, 1);
    chk("t4_data", pd0, mk(8'h40));

    // short low glitch on idle line
    sbv = nbv; spe = npe; sfe = nfe;
    rx0 = 1'b0;
    repeat (4) @(negedge clk_50M);
    rx0 = 1'b1;
    repeat (3 * CPB) @(negedge clk_50M);
    chk("t5_nobyte", nbv - sbv, 0);
    chk("t5_noerr", (npe - spe) + (nfe - sfe), 0);
    chk("t5_busy", by0, 1'b0);

    // reset during frame 7
    for (int k = 0; k < 6; k++) send(8'h60 + 8'(k), 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk_50M);
    #1;
    chk("t6_busy", by0, 1'b0);
    chk("t6_data", pd0, '0);
    chk("t6_flags", {pv0, bv0, pe0, fe0}, 4'b0);
    @(negedge clk_50M);
    rx0   = 1'b1;
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk_50M);
    spv = npv;
    for (int k = 0; k < NB; k++) send(8'hFF, 1'b0, 1'b0, 1'b0);
    chk("t6_pkts", npv - spv, 1);
    chk("t6_ones", pd0, {PW{1'b1}});
    chk("pv_with_bv", nsync, 0);

    // odd parity instance
    sopv = opv; sope = ope;
    send_pkt(8'h00, 1'b1);
    chk("odd_bytes", obv, NB);
    chk("odd_pkts", opv - sopv, 1);
    chk("odd_perr", ope - sope, 0);
    chk("odd_data", pd1, mk(8'h00));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
